// File: rtl/cnn1d_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn1d_pkg
// Purpose  : Shared constants for the 1-D CNN datapath.
// Revision : 1.0
// ============================================================================
package cnn1d_pkg;
  parameter int DATA_WIDTH = 16;
endpackage
`default_nettype wire

// File: rtl/window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : window_buffer
// Purpose  : Serial-to-window stage feeding a neuron, with stride and
//            sequence-boundary handling.
// Revision : 1.0
// ============================================================================
module window_buffer
  import cnn1d_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int SEQ_LEN     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         win_ready_in,
  input  logic                         win_valid_in,
  input  logic signed [DATA_WIDTH-1:0] win_data_in,
  input  logic                         win_ready_out,
  output logic                         win_valid_out,
  output logic signed [DATA_WIDTH-1:0] win_data_out [0:KERNEL_SIZE-1],
  output logic                         win_last_out
);

  localparam int C_IDX_W  = $clog2(SEQ_LEN) + 1;
  localparam int C_FILL_W = $clog2(KERNEL_SIZE) + 1;
  localparam int C_STR_W  = $clog2(STRIDE) + 1;

  localparam logic [C_IDX_W-1:0]  C_IDX_LAST = C_IDX_W'(SEQ_LEN - 1);
  localparam logic [C_FILL_W-1:0] C_KERNEL   = C_FILL_W'(KERNEL_SIZE);
  localparam logic [C_STR_W-1:0]  C_STRIDE   = C_STR_W'(STRIDE);

  generate
    if (KERNEL_SIZE < 1 || STRIDE < 1 || SEQ_LEN < KERNEL_SIZE) begin : g_param_check
      $error("window_buffer: need KERNEL_SIZE>=1, STRIDE>=1, SEQ_LEN>=KERNEL_SIZE");
    end
  endgenerate

  logic signed [DATA_WIDTH-1:0] r_shift [0:KERNEL_SIZE-1];
  logic signed [DATA_WIDTH-1:0] w_shift [0:KERNEL_SIZE-1];
  logic [C_IDX_W-1:0]           r_idx;
  logic [C_FILL_W-1:0]          r_fill;
  logic [C_FILL_W-1:0]          w_fill_next;
  logic [C_STR_W-1:0]           r_stride;
  logic [C_STR_W-1:0]           w_stride_next;
  logic                         w_accept;
  logic                         w_fill_full;
  logic                         w_complete;
  logic                         w_idx_wrap;
  logic                         w_last;

  // Combinational ready keeps full throughput while the neuron keeps up.
  assign win_ready_in = rst && (!win_valid_out || win_ready_out);
  assign w_accept     = win_valid_in && win_ready_in;

  always_comb begin
    w_shift = r_shift;
    for (int i = 0; i < KERNEL_SIZE - 1; i++) begin
      w_shift[i] = r_shift[i+1];
    end
    w_shift[KERNEL_SIZE-1] = win_data_in;
  end

  assign w_fill_full   = (r_fill == C_KERNEL);
  assign w_fill_next   = r_fill + C_FILL_W'(1);
  assign w_stride_next = r_stride + C_STR_W'(1);
  assign w_complete    = w_accept &&
                         (w_fill_full ? (w_stride_next == C_STRIDE)
                                      : (w_fill_next == C_KERNEL));
  assign w_idx_wrap    = (r_idx == C_IDX_LAST);
  // Last window when another stride would run past the sequence end.
  assign w_last        = (int'(r_idx) + STRIDE) > (SEQ_LEN - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        r_shift[i] <= '0;
      end
      r_idx    <= '0;
      r_fill   <= '0;
      r_stride <= '0;
    end else if (w_accept) begin
      r_shift <= w_shift;
      if (w_idx_wrap) begin
        r_idx    <= '0;
        r_fill   <= '0;
        r_stride <= '0;
      end else begin
        r_idx <= r_idx + C_IDX_W'(1);
        if (!w_fill_full) begin
          r_fill <= w_fill_next;
        end
        if (w_complete) begin
          r_stride <= '0;
        end else if (w_fill_full) begin
          r_stride <= w_stride_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        win_data_out[i] <= '0;
      end
      win_valid_out <= 1'b0;
      win_last_out  <= 1'b0;
    end else if (w_complete) begin
      win_data_out  <= w_shift;
      win_valid_out <= 1'b1;
      win_last_out  <= w_last;
    end else if (win_valid_out && win_ready_out) begin
      // Data is kept after a drain; only the qualifiers drop.
      win_valid_out <= 1'b0;
      win_last_out  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_buffer
// Purpose  : Directed self-checking bench for window_buffer in three configs.
// Revision : 1.0
// ============================================================================
module tb_window_buffer;
  import cnn1d_pkg::*;

  logic clk;
  logic rst;
  logic signed [DATA_WIDTH-1:0] din;
  logic vin_a, vin_b, vin_c, rout_a;

  logic a_rin, a_vout, a_last;
  logic b_rin, b_vout, b_last;
  logic c_rin, c_vout, c_last;
  logic signed [DATA_WIDTH-1:0] a_dout [0:2];
  logic signed [DATA_WIDTH-1:0] b_dout [0:2];
  logic signed [DATA_WIDTH-1:0] c_dout [0:2];
  logic [47:0] a_win, b_win, c_win;

  int total = 0;
  int bad   = 0;
  logic ev_a, ev_b, ev_c, el_b, el_c;

  assign a_win = {a_dout[0], a_dout[1], a_dout[2]};
  assign b_win = {b_dout[0], b_dout[1], b_dout[2]};
  assign c_win = {c_dout[0], c_dout[1], c_dout[2]};

  window_buffer #(.KERNEL_SIZE(3), .STRIDE(1), .SEQ_LEN(8)) u_a (
    .clk(clk), .rst(rst), .win_ready_in(a_rin), .win_valid_in(vin_a),
    .win_data_in(din), .win_ready_out(rout_a), .win_valid_out(a_vout),
    .win_data_out(a_dout), .win_last_out(a_last));

  window_buffer #(.KERNEL_SIZE(3), .STRIDE(2), .SEQ_LEN(8)) u_b (
    .clk(clk), .rst(rst), .win_ready_in(b_rin), .win_valid_in(vin_b),
    .win_data_in(din), .win_ready_out(1'b1), .win_valid_out(b_vout),
    .win_data_out(b_dout), .win_last_out(b_last));

  window_buffer #(.KERNEL_SIZE(3), .STRIDE(1), .SEQ_LEN(4)) u_c (
    .clk(clk), .rst(rst), .win_ready_in(c_rin), .win_valid_in(vin_c),
    .win_data_in(din), .win_ready_out(1'b1), .win_valid_out(c_vout),
    .win_data_out(c_dout), .win_last_out(c_last));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] w3(input int x, input int y, input int z);
    return {x[15:0], y[15:0], z[15:0]};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; din = '0; vin_a = 0; vin_b = 0; vin_c = 0; rout_a = 1'b1;
    #2;
    chk1("rst_a_vout", a_vout, 1'b0);
    chk1("rst_a_rin", a_rin, 1'b0);
    chk1("rst_a_last", a_last, 1'b0);
    chkw("rst_a_win", a_win, 48'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Same stream 1..8 into all three configurations.
    for (int i = 1; i <= 8; i++) begin
      din = 16'(i); vin_a = 1; vin_b = 1; vin_c = 1;
      @(negedge clk);
      chk1("flow_a_rin", a_rin, 1'b1);
      chk1("flow_b_rin", b_rin, 1'b1);
      chk1("flow_c_rin", c_rin, 1'b1);
      @(posedge clk); #1;
      ev_a = (i >= 3);
      ev_b = (i == 3 || i == 5 || i == 7);
      el_b = (i == 7);
      ev_c = (i == 3 || i == 4 || i == 7 || i == 8);
      el_c = (i == 4 || i == 8);
      chk1("s1_vout", a_vout, ev_a);
      chk1("s1_last", a_last, (i == 8));
      if (ev_a) chkw("s1_win", a_win, w3(i-2, i-1, i));
      chk1("s2_vout", b_vout, ev_b);
      chk1("s2_last", b_last, el_b);
      if (ev_b) chkw("s2_win", b_win, w3(i-2, i-1, i));
      chk1("l4_vout", c_vout, ev_c);
      chk1("l4_last", c_last, el_c);
      if (ev_c) chkw("l4_win", c_win, w3(i-2, i-1, i));
    end
    vin_b = 0; vin_c = 0;

    // Backpressure on the K=3,S=1 instance.
    for (int i = 1; i <= 3; i++) begin
      din = 16'(i); vin_a = 1;
      @(posedge clk); #1;
    end
    chk1("bp_first_vout", a_vout, 1'b1);
    chkw("bp_first_win", a_win, w3(1, 2, 3));
    rout_a = 1'b0; din = 16'd4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("bp_stall_rin", a_rin, 1'b0);
      chk1("bp_stall_vout", a_vout, 1'b1);
      chkw("bp_stall_win", a_win, w3(1, 2, 3));
      @(posedge clk); #1;
    end
    rout_a = 1'b1;
    @(negedge clk);
    chk1("bp_release_rin", a_rin, 1'b1);
    @(posedge clk); #1;
    chk1("bp_next_vout", a_vout, 1'b1);
    chkw("bp_next_win", a_win, w3(2, 3, 4));
    chk1("bp_next_last", a_last, 1'b0);
    vin_a = 0;
    @(posedge clk); #1;
    chk1("bp_drain_vout", a_vout, 1'b0);

    // Signed samples through the S=2 instance (fresh sequence).
    din = -16'sd5; vin_b = 1;
    @(posedge clk); #1;
    din = 16'sd5;
    @(posedge clk); #1;
    din = -16'sd10;
    @(posedge clk); #1;
    vin_b = 0;
    chk1("signed_vout", b_vout, 1'b1);
    chkw("signed_win", b_win, 48'hFFFB_0005_FFF6);

    // Reset mid-sequence on the L=4 instance.
    din = 16'd1; vin_c = 1;
    @(posedge clk); #1;
    din = 16'd2;
    @(posedge clk); #1;
    vin_c = 0;
    #2 rst = 1'b0;
    #1;
    chk1("mr_vout", c_vout, 1'b0);
    chk1("mr_rin", c_rin, 1'b0);
    chk1("mr_last", c_last, 1'b0);
    chkw("mr_win", c_win, 48'h0);
    chkw("mr_b_win", b_win, 48'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    din = 16'd7; vin_c = 1;
    @(posedge clk); #1;
    din = 16'd8;
    @(posedge clk); #1;
    chk1("mr_early_vout", c_vout, 1'b0);
    din = 16'd9;
    @(posedge clk); #1;
    chk1("mr_first_vout", c_vout, 1'b1);
    chkw("mr_first_win", c_win, w3(7, 8, 9));
    chk1("mr_first_last", c_last, 1'b0);
    din = 16'd10;
    @(posedge clk); #1;
    vin_c = 0;
    chkw("mr_second_win", c_win, w3(8, 9, 10));
    chk1("mr_second_last", c_last, 1'b1);
    @(posedge clk); #1;
    chk1("mr_drain_vout", c_vout, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
